// File: rtl/key_lut_if.sv
// Lookup request/response channel of key_lut: valid/ready request carrying a key,
// valid/ready response carrying data plus hit/multi-hit flags.
interface key_lut_if #(
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [KEY_LEN-1:0]  req_key;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_LEN-1:0] rsp_data;
    logic                rsp_hit;
    logic                rsp_multi;

    modport master (
        output req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_multi
    );

    modport slave (
        input  req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_multi
    );
endinterface

// File: rtl/key_lut.sv
// Writable key->data lookup table; lookups answered from a registered response stage.
// Latency: 1 cycle accept-to-rsp_valid, 1 lookup/cycle; optional KEY_LUT_PRIO_EN picks lowest index on multi-hit.
// Backpressure: req_ready = !rsp_valid | rsp_ready; response held stable while rsp_ready is low.
module key_lut #(
    parameter int                  NR_KEY      = 8,
    parameter int                  KEY_LEN     = 7,
    parameter int                  DATA_LEN    = 32,
    parameter int                  HAS_DEFAULT = 1,
    parameter logic [DATA_LEN-1:0] DEFAULT_OUT = '0,
    localparam int                 IDX_W       = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                inv_en,
    input  logic [IDX_W-1:0]    inv_idx,
    input  logic                clr,
    key_lut_if.slave            lk,
    output logic [IDX_W:0]      occupancy
);

    logic [NR_KEY-1:0]   vld_q, vld_d;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [KEY_LEN-1:0]  key_d  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] data_d [NR_KEY];
    logic [IDX_W:0]      occ_q, occ_d;

    logic                rsp_vld_q, rsp_vld_d;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic                rsp_multi_q, rsp_multi_d;

    logic [DATA_LEN-1:0] look_data;
    logic                look_hit;
    logic                look_multi;
    logic                accept;

    // Table update: invalidate is applied after the write so it wins on a shared index.
    always_comb begin
        vld_d  = vld_q;
        key_d  = key_q;
        data_d = data_q;
        if (clr) begin
            vld_d = '0;
        end else begin
            if (wr_en && (int'(wr_idx) < NR_KEY)) begin
                vld_d[wr_idx]  = 1'b1;
                key_d[wr_idx]  = wr_key;
                data_d[wr_idx] = wr_data;
            end
            if (inv_en && (int'(inv_idx) < NR_KEY)) begin
                vld_d[inv_idx] = 1'b0;
            end
        end
        occ_d = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            occ_d = occ_d + (IDX_W+1)'(vld_d[i]);
        end
    end

    // Match against pre-edge table state; scanning downward leaves the lowest index last.
    always_comb begin
        int hit_cnt;
        hit_cnt   = 0;
        look_data = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (vld_q[i] && (key_q[i] == lk.req_key)) begin
                hit_cnt = hit_cnt + 1;
`ifdef KEY_LUT_PRIO_EN
                look_data = data_q[i];
`else
                look_data = look_data | data_q[i];
`endif
            end
        end
        look_hit = (hit_cnt != 0);
`ifdef KEY_LUT_PRIO_EN
        look_multi = (hit_cnt > 1);
`else
        look_multi = 1'b0;
`endif
        if (!look_hit) begin
            look_data = (HAS_DEFAULT != 0) ? DEFAULT_OUT : '0;
        end
    end

    assign lk.req_ready = !rsp_vld_q || lk.rsp_ready;
    assign accept       = lk.req_valid && lk.req_ready;

    always_comb begin
        rsp_vld_d   = rsp_vld_q;
        rsp_data_d  = rsp_data_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_multi_d = rsp_multi_q;
        if (accept) begin
            rsp_vld_d   = 1'b1;
            rsp_data_d  = look_data;
            rsp_hit_d   = look_hit;
            rsp_multi_d = look_multi;
        end else if (lk.rsp_ready) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            occ_q       <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_multi_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            occ_q       <= occ_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_multi_q <= rsp_multi_d;
        end
    end

    // Key/data storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        key_q  <= key_d;
        data_q <= data_d;
    end

    assign lk.rsp_valid = rsp_vld_q;
    assign lk.rsp_data  = rsp_data_q;
    assign lk.rsp_hit   = rsp_hit_q;
    assign lk.rsp_multi = rsp_multi_q;
    assign occupancy    = occ_q;

endmodule
